// File: rtl/eeprom_pkg.sv
// Shared types and defaults for the EEPROM request arbiter.
// Holds the FSM state encoding and page/recovery defaults.
package eeprom_pkg;

   localparam int PAGE_BITS = 5;
   localparam int PAGE_DEF = 1 << PAGE_BITS;
   localparam int TWR_CYC_DEF = 2000;
   localparam int REM_W = 9;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_WAIT,
      S_RECOVER,
      S_FIN
   } state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority encoder: first set request at or after ptr,
// wrapping, returned both one-hot and as an index.
module rr_pick
   import eeprom_pkg::*;
#(
   parameter int N = 2,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);

   int j;

   always_comb begin
      onehot = '0;
      idx = '0;
      any = 1'b0;
      j = 0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr) + i) % N;
         if (!any && req[j]) begin
            any = 1'b1;
            onehot[j] = 1'b1;
            idx = IW'(j);
         end
      end
   end

endmodule

// File: rtl/eeprom_req_arbiter.sv
// Round-robin sharing of one I2C EEPROM page engine, page-chunked.
// Define EEPROM_RETRY_EN to reissue NACKed chunks up to MAX_RETRY.
module eeprom_req_arbiter
   import eeprom_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int AW = 13,
   parameter int PAGE = PAGE_DEF,
   parameter int TWR_CYC = TWR_CYC_DEF,
   parameter int MAX_RETRY = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          req_wr,
   input  logic [NREQ*AW-1:0]       req_addr,
   input  logic [NREQ*8-1:0]        req_len,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          done,
   output logic                     err,
   output logic                     busy,
   output logic                     eng_start,
   output logic                     eng_wr,
   output logic [AW-1:0]            eng_addr,
   output logic [$clog2(PAGE)-1:0]  eng_len,
   input  logic                     eng_done,
   input  logic                     eng_nack
);

   localparam int PB = $clog2(PAGE);
   localparam int IW = idx_w(NREQ);
   localparam int TW = idx_w(TWR_CYC);
   localparam int RTW = idx_w(MAX_RETRY + 1);

`ifdef EEPROM_RETRY_EN
   localparam int RETRY_LIM = MAX_RETRY;
`else
   localparam int RETRY_LIM = 0;
`endif

   state_t state, state_nx;

   logic [NREQ-1:0]  pick_hot;
   logic [IW-1:0]    pick_idx;
   logic             pick_any;
   logic [IW-1:0]    owner;
   logic [IW-1:0]    ptr;
   logic             wr_q;
   logic [AW-1:0]    addr_q;
   logic [REM_W-1:0] rem_q;
   logic             more_q;
   logic             err_q;
   logic [TW-1:0]    twr_cnt;
   logic [RTW-1:0]   retry_cnt;
   logic [PB-1:0]    room_m1;
   logic [PB-1:0]    chunk_m1;
   logic             last;
   logic             can_retry;
   logic             twr_end;

   rr_pick #(
      .N  (NREQ),
      .IW (IW)
   ) u_pick (
      .req    (req),
      .ptr    (ptr),
      .onehot (pick_hot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   // rem and eng_len both hold "count minus 1", so min() works directly
   always_comb begin
      room_m1 = ~addr_q[PB-1:0];
      if (rem_q < REM_W'(room_m1))
         chunk_m1 = rem_q[PB-1:0];
      else
         chunk_m1 = room_m1;
      last = REM_W'(eng_len) >= rem_q;
      can_retry = retry_cnt != RTW'(RETRY_LIM);
      twr_end = twr_cnt == TW'(TWR_CYC - 1);
   end

   assign busy = state != S_IDLE;
   assign done = (state == S_FIN) ? gnt : '0;
   assign err = (state == S_FIN) & err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (pick_any) state_nx = S_CALC;
         end
         S_CALC: state_nx = S_WAIT;
         S_WAIT: begin
            if (eng_done) begin
               if (eng_nack)
                  state_nx = can_retry ? S_CALC : S_FIN;
               else if (wr_q)
                  state_nx = S_RECOVER;
               else
                  state_nx = last ? S_FIN : S_CALC;
            end
         end
         S_RECOVER: begin
            if (twr_end) state_nx = more_q ? S_CALC : S_FIN;
         end
         S_FIN: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt <= '0;
         owner <= '0;
         ptr <= '0;
         wr_q <= 1'b0;
         addr_q <= '0;
         rem_q <= '0;
         more_q <= 1'b0;
         err_q <= 1'b0;
         twr_cnt <= '0;
         retry_cnt <= '0;
         eng_start <= 1'b0;
         eng_wr <= 1'b0;
         eng_addr <= '0;
         eng_len <= '0;
      end else begin
         eng_start <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (pick_any) begin
                  gnt <= pick_hot;
                  owner <= pick_idx;
                  wr_q <= req_wr[pick_idx];
                  addr_q <= req_addr[int'(pick_idx)*AW +: AW];
                  rem_q <= {1'b0, req_len[int'(pick_idx)*8 +: 8]};
                  err_q <= 1'b0;
                  retry_cnt <= '0;
               end
            end
            S_CALC: begin
               eng_start <= 1'b1;
               eng_wr <= wr_q;
               eng_addr <= addr_q;
               eng_len <= chunk_m1;
            end
            S_WAIT: begin
               twr_cnt <= '0;
               if (eng_done) begin
                  if (eng_nack) begin
                     if (can_retry) retry_cnt <= retry_cnt + 1'b1;
                     else           err_q <= 1'b1;
                  end else begin
                     addr_q <= addr_q + AW'(eng_len) + 1'b1;
                     rem_q <= rem_q - REM_W'(eng_len) - 1'b1;
                     more_q <= !last;
                     retry_cnt <= '0;
                  end
               end
            end
            S_RECOVER: twr_cnt <= twr_cnt + 1'b1;
            S_FIN: begin
               gnt <= '0;
               ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_eeprom_req_arbiter.sv
// Randomized bench for eeprom_req_arbiter with a chunk-list model.
// Honours EEPROM_RETRY_EN for the expected NACK behaviour.
module tb_eeprom_req_arbiter;

   localparam int NREQ = 2;
   localparam int AW = 13;
   localparam int PAGE = 32;
   localparam int TWR = 2000;

`ifdef EEPROM_RETRY_EN
   localparam int RETRIES = 3;
`else
   localparam int RETRIES = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NREQ-1:0] req = '0;
   logic [NREQ-1:0] req_wr = '0;
   logic [NREQ*AW-1:0] req_addr = '0;
   logic [NREQ*8-1:0] req_len = '0;
   logic [NREQ-1:0] gnt;
   logic [NREQ-1:0] done;
   logic err;
   logic busy;
   logic eng_start;
   logic eng_wr;
   logic [AW-1:0] eng_addr;
   logic [4:0] eng_len;
   logic eng_done = 1'b0;
   logic eng_nack = 1'b0;

   int total = 0;
   int bad = 0;
   int mptr = 0;

   always #5 clk = ~clk;

   eeprom_req_arbiter #(
      .NREQ      (NREQ),
      .AW        (AW),
      .PAGE      (PAGE),
      .TWR_CYC   (TWR),
      .MAX_RETRY (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .gnt       (gnt),
      .done      (done),
      .err       (err),
      .busy      (busy),
      .eng_start (eng_start),
      .eng_wr    (eng_wr),
      .eng_addr  (eng_addr),
      .eng_len   (eng_len),
      .eng_done  (eng_done),
      .eng_nack  (eng_nack)
   );

   task automatic set_req(input int who, input bit wr,
                          input int addr, input int len);
      req_wr[who] = wr;
      req_addr[who*AW +: AW] = AW'(addr);
      req_len[who*8 +: 8] = 8'(len);
   endtask

   function automatic int pick(input logic [NREQ-1:0] mask);
      for (int i = 0; i < NREQ; i++)
         if (mask[(mptr + i) % NREQ]) return (mptr + i) % NREQ;
      return -1;
   endfunction

   // Acts as the page engine for one granted transfer and checks it
   // against the page-split chunk list derived from addr/len.
   task automatic serve(input int who, input bit wr, input int addr,
                        input int len, input int nk, input int nt);
      int a, n, c, ci, k, cnt, gap, want;
      bit e, nack, retry;
      logic [NREQ-1:0] own;
      own = NREQ'(1 << who);
      cnt = 0;
      while (!gnt[who] && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      total++;
      if (gnt !== own) begin
         bad++;
         $display("FAIL grant: got %b want %b", gnt, own);
      end
      if ($urandom_range(0, 3) == 0) req[who] = 1'b0;
      a = addr;
      n = len + 1;
      ci = 0;
      e = 1'b0;
      gap = 1;
      while (n > 0 && !e) begin
         c = PAGE - (a % PAGE);
         if (c > n) c = n;
         k = 0;
         retry = 1'b1;
         while (retry) begin
            cnt = 0;
            while (!eng_start && cnt < gap + 20) begin
               @(negedge clk);
               cnt++;
            end
            total++;
            if (cnt != gap) begin
               bad++;
               $display("FAIL start_gap: got %0d want %0d", cnt, gap);
            end
            total++;
            if (eng_addr !== AW'(a) || eng_len !== 5'(c - 1) ||
                eng_wr !== wr) begin
               bad++;
               $display("FAIL chunk: got %h/%0d/%b want %h/%0d/%b",
                        eng_addr, eng_len, eng_wr, a, c - 1, wr);
            end
            @(negedge clk);
            total++;
            if (eng_start !== 1'b0) begin
               bad++;
               $display("FAIL start_pulse: got %b want 0", eng_start);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            total++;
            if (eng_addr !== AW'(a) || eng_len !== 5'(c - 1)) begin
               bad++;
               $display("FAIL hold: got %h/%0d want %h/%0d",
                        eng_addr, eng_len, a, c - 1);
            end
            nack = (ci == nk) && (k < nt);
            eng_done = 1'b1;
            eng_nack = nack;
            @(negedge clk);
            eng_done = 1'b0;
            eng_nack = 1'b0;
            if (!nack) begin
               retry = 1'b0;
            end else if (k >= RETRIES) begin
               retry = 1'b0;
               e = 1'b1;
            end else begin
               k++;
               gap = 1;
            end
         end
         if (!e) begin
            a = (a + c) % (1 << AW);
            n -= c;
            ci++;
            gap = wr ? TWR + 1 : 1;
         end
      end
      want = (wr && !e) ? TWR : 0;
      cnt = 0;
      while (!done[who] && cnt < TWR + 20) begin
         @(negedge clk);
         cnt++;
      end
      total++;
      if (cnt != want) begin
         bad++;
         $display("FAIL done_lat: got %0d want %0d", cnt, want);
      end
      total++;
      if (done !== own || err !== e) begin
         bad++;
         $display("FAIL done: got %b/%b want %b/%b", done, err, own, e);
      end
      total++;
      if (gnt !== own) begin
         bad++;
         $display("FAIL gnt_hold: got %b want %b", gnt, own);
      end
      req[who] = 1'b0;
      mptr = (who + 1) % NREQ;
      @(negedge clk);
      total++;
      if (gnt[who] !== 1'b0 || done !== '0) begin
         bad++;
         $display("FAIL release: got %b/%b want 0/0", gnt, done);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({gnt, done, err, busy, eng_start, eng_wr, eng_addr, eng_len}
          !== '0) begin
         bad++;
         $display("FAIL reset: got %b/%b/%b/%b/%b want all 0",
                  gnt, done, err, busy, eng_start);
      end
      rst = 1'b0;
      mptr = 0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle: got %b want 0", busy);
      end
   endtask

   task automatic test_read;
      set_req(0, 1'b0, 'h0010, 3);
      req[0] = 1'b1;
      @(negedge clk);
      total++;
      if (gnt !== 2'b01 || busy !== 1'b1) begin
         bad++;
         $display("FAIL req_to_gnt: got %b/%b want 01/1", gnt, busy);
      end
      serve(0, 1'b0, 'h0010, 3, -1, 0);
   endtask

   task automatic test_write_page;
      set_req(1, 1'b1, 'h001E, 5);
      req[1] = 1'b1;
      serve(1, 1'b1, 'h001E, 5, -1, 0);
   endtask

   task automatic test_contention;
      for (int r = 0; r < 2; r++) begin
         set_req(0, 1'b0, 'h0200 + r, 40);
         set_req(1, 1'b0, 'h0300 + r, 2);
         req = 2'b11;
         serve(0, 1'b0, 'h0200 + r, 40, -1, 0);
         serve(1, 1'b0, 'h0300 + r, 2, -1, 0);
      end
   endtask

   task automatic test_wrap;
      set_req(0, 1'b0, 'h1FFF, 1);
      req[0] = 1'b1;
      serve(0, 1'b0, 'h1FFF, 1, -1, 0);
      set_req(0, 1'b0, 'h0400, 255);
      req[0] = 1'b1;
      serve(0, 1'b0, 'h0400, 255, -1, 0);
   endtask

   task automatic test_nack;
      bit seen;
      for (int t = 1; t <= 4; t += 3) begin
         set_req(1, 1'b0, 'h001E, 5);
         req[1] = 1'b1;
         serve(1, 1'b0, 'h001E, 5, 1, t);
         seen = 1'b0;
         repeat (6) begin
            @(negedge clk);
            if (eng_start || busy) seen = 1'b1;
         end
         total++;
         if (seen) begin
            bad++;
            $display("FAIL after_nack: got activity want idle");
         end
      end
   endtask

   task automatic test_idle_done;
      eng_done = 1'b1;
      @(negedge clk);
      eng_done = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== '0 || eng_start !== 1'b0) begin
         bad++;
         $display("FAIL idle_done: got %b/%b/%b want 0/0/0",
                  busy, done, eng_start);
      end
   endtask

   task automatic test_rst_recover;
      int cnt, w;
      set_req(0, 1'b0, 'h0100, 7);
      req[0] = 1'b1;
      serve(0, 1'b0, 'h0100, 7, -1, 0);
      set_req(1, 1'b1, 'h0040, 40);
      req[1] = 1'b1;
      cnt = 0;
      while (!eng_start && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      eng_done = 1'b1;
      @(negedge clk);
      eng_done = 1'b0;
      repeat (100) @(negedge clk);
      total++;
      if (busy !== 1'b1 || done !== '0) begin
         bad++;
         $display("FAIL in_recover: got %b/%b want 1/00", busy, done);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (gnt !== '0 || busy !== 1'b0 || done !== '0) begin
         bad++;
         $display("FAIL async_rst: got %b/%b/%b want 00/0/00",
                  gnt, busy, done);
      end
      req = '0;
      @(negedge clk);
      rst = 1'b0;
      mptr = 0;
      set_req(0, 1'b0, 'h0500, 1);
      set_req(1, 1'b0, 'h0600, 1);
      req = 2'b11;
      w = pick(2'b11);
      serve(w, 1'b0, 'h0500 + w * 'h100, 1, -1, 0);
      serve(1 - w, 1'b0, 'h0500 + (1 - w) * 'h100, 1, -1, 0);
   endtask

   task automatic test_random;
      int wr_a[NREQ], ad_a[NREQ], ln_a[NREQ], nk_a[NREQ], nt_a[NREQ];
      int nwr, first;
      logic [NREQ-1:0] mask;
      nwr = 0;
      for (int it = 0; it < 10; it++) begin
         mask = NREQ'($urandom_range(1, 3));
         for (int i = 0; i < NREQ; i++) begin
            wr_a[i] = (nwr < 4 && $urandom_range(0, 3) == 0) ? 1 : 0;
            if (mask[i] && wr_a[i] == 1) nwr++;
            ad_a[i] = $urandom_range(0, 8191);
            ln_a[i] = wr_a[i] == 1 ? $urandom_range(0, 31)
                                   : $urandom_range(0, 255);
            nk_a[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2)
                                                  : -1;
            nt_a[i] = $urandom_range(1, 4);
            set_req(i, wr_a[i] == 1, ad_a[i], ln_a[i]);
         end
         req = mask;
         first = pick(mask);
         serve(first, wr_a[first] == 1, ad_a[first], ln_a[first],
               nk_a[first], nt_a[first]);
         if (mask == 2'b11)
            serve(1 - first, wr_a[1 - first] == 1, ad_a[1 - first],
                  ln_a[1 - first], nk_a[1 - first], nt_a[1 - first]);
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write_page();
      test_contention();
      test_wrap();
      test_nack();
      test_idle_done();
      test_rst_recover();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/eeprom_req_arbiter.md
Name: eeprom_req_arbiter

Overview:
- Shares one I2C EEPROM page engine (24C64-class, 32-byte pages) between NREQ requesters.
- Accepts byte-range read/write requests and grants the engine round-robin.
- Splits each request into page-aligned chunks and sequences the engine chunk by chunk.
- After every write chunk, enforces the EEPROM write-cycle recovery time. Runs in the 400 kHz I2C clock domain.

Parameters:
- NREQ, 2, number of requesters.
- AW, 13, EEPROM byte-address width.
- PAGE, 32, page size in bytes (power of two).
- TWR_CYC, 2000, write-recovery wait in clk cycles (5 ms at 400 kHz).
- MAX_RETRY, 3, NACK retries per chunk (RETRY_EN only).

Ports:
- clk  in  1  I2C-domain clock.
- rst  in  1  Asynchronous active-high reset.
- req  in  NREQ  Request level per requester; held until done.
- req_wr  in  NREQ  1 = write, 0 = read; sampled at grant.
- req_addr  in  NREQ*AW  Start byte address per requester; sampled at grant.
- req_len  in  NREQ*8  Byte count minus 1 (1..256 bytes); sampled at grant.
- gnt  out  NREQ  One-hot grant; high from acceptance through the done cycle.
- done  out  NREQ  1-cycle completion pulse to the owner.
- err  out  1  Valid with done: transfer aborted on NACK.
- busy  out  1  State is not IDLE.
- eng_start  out  1  1-cycle chunk start to the page engine.
- eng_wr  out  1  Chunk direction.
- eng_addr  out  AW  Chunk start address.
- eng_len  out  log2(PAGE)  Chunk byte count minus 1.
- eng_done  in  1  1-cycle pulse when the engine finishes a chunk.
- eng_nack  in  1  Qualified by eng_done: slave NACKed.

Behaviour:
- Reset values: all outputs 0; round-robin pointer = 0; state IDLE.
- States:
  - IDLE: when any req is high, pick the first requester at or after the pointer (wrapping); latch wr/addr/len; assert gnt next cycle; go to CALC.
  - CALC: chunk = min(rem, PAGE - addr[log2(PAGE)-1:0]); drive eng_* and pulse eng_start for one cycle; go to WAIT.
  - WAIT: hold eng_addr/eng_len/eng_wr stable until eng_done.
    - On eng_done without nack: addr += chunk (wraps modulo 2^AW); rem -= chunk.
    - Then go to RECOVER if wr, else to CALC if rem > 0, else to FIN.
  - RECOVER: count TWR_CYC cycles, then go to CALC if rem > 0, else to FIN.
  - FIN: pulse done[owner] with err; drop gnt after this cycle; pointer = owner+1 mod NREQ; go to IDLE.
- Latency: req high to eng_start is 2 cycles. Final eng_done to done is 1 cycle for reads and TWR_CYC+1 cycles for writes.
- rem holds the remaining byte count minus 1 as 9 bits; the transfer finishes when the last chunk covers rem.
- Boundaries:
  - Address 0x1FFF with 2 bytes gives chunk 1 byte at 0x1FFF, then chunk 1 byte at 0x0000.
  - Length 256 starting page-aligned gives 8 chunks.
- Deasserting req while granted is ignored; the transfer completes. A new req is seen only after return to IDLE.
- eng_done outside WAIT is ignored.
- Asynchronous rst mid-transfer: return immediately to the reset state with no done pulse.
- Data bytes are muxed to the engine by gnt outside this block.

Optional Feature:
- Macro: EEPROM_RETRY_EN.
- Defined: on eng_nack, reissue the same chunk (back to CALC, addr/rem unchanged) up to MAX_RETRY times; a per-chunk counter resets on each successful chunk. On exhausting retries, go to FIN with err=1.
- Undefined: the first eng_nack goes directly to FIN with err=1. MAX_RETRY is unused.

Decomposition:
- Package eeprom_pkg: state enum, PAGE_BITS = log2(PAGE), TWR_CYC default.
- Sub-module rr_pick: combinational round-robin priority encoder (req, pointer -> one-hot and index), reusable elsewhere.

Test Plan:
- Single read, req0, addr 0x0010, len 3 (4 bytes): one eng_start, addr 0x0010, eng_len 3. done[0] 1 cycle after eng_done, err=0.
- Write crossing a page, req1, addr 0x001E, len 5 (6 bytes): chunks (0x001E, len 1) then (0x0020, len 3). Each chunk followed by 2000 idle cycles, then done[1].
- Contention, req0 and req1 high together with pointer=0: req0 served first, then req1. Next simultaneous pair after a req1 completion serves req0 first.
- Address wrap, read at 0x1FFF with len 1: chunks at 0x1FFF and 0x0000, each eng_len 0.
- NACK on the 2nd chunk:
  - Without the macro: done with err=1 and no further eng_start.
  - With the macro: 3 reissues at the same addr, then err=1. A NACK followed by success gives err=0.
- rst asserted during RECOVER: gnt/busy drop asynchronously, no done pulse. The next req restarts with pointer 0.
